// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request open at a time,
// and feeds {instr, incPC, valid} to IF/ID. It takes redirects from execute and stops fetching after HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] newPC,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr_out,
  output logic [15:0] incPC_out,
  output logic        valid_out,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    HALTED
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] drop_addr;
  logic [15:0] pc_plus2;
  logic        req_open;

  assign pc_plus2 = pc + 16'd2;

  always_comb begin
    req_open = 1'b0;
    case (state)
      FETCH:   req_open = ~stall;
      DROP:    req_open = 1'b1;
      default: req_open = 1'b0;
    endcase
  end

  // Reset pulls the strobe down at once, so the memory can abandon a request in flight.
  assign imem_req  = req_open & ~rst;
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      instr_out <= NOP_INSTR;
      incPC_out <= 16'h0000;
      valid_out <= 1'b0;
      halted    <= 1'b0;
    end else if (redirect) begin
      pc        <= newPC & 16'hFFFE;
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
      halted    <= 1'b0;
      // An unanswered request still has to drain at its old address before a new one goes out.
      if (req_open && !imem_ready) begin
        state     <= DROP;
        drop_addr <= imem_addr;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (!stall) begin
            if (imem_ready) begin
              instr_out <= imem_rdata;
              incPC_out <= pc_plus2;
              valid_out <= 1'b1;
              pc        <= pc_plus2;
              if (imem_rdata[15:11] == HALT_OPC) begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end else begin
              valid_out <= 1'b0;
              instr_out <= NOP_INSTR;
            end
          end
        end
        DROP: begin
          if (imem_ready) state <= FETCH;
        end
        HALTED: begin
          if (!stall) begin
            valid_out <= 1'b0;
            instr_out <= NOP_INSTR;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
